// File: rtl/fir_pkg.sv
// Shared FIR coefficient-loader types: FSM state encoding and default geometry.
package fir_pkg;

  localparam int DEF_NUM_TAPS = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } load_state_t;

endpackage

// File: rtl/coeff_loader_if.sv
// Coefficient stream (valid/ready) carrying data and tap index.
interface coeff_loader_if
  import fir_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              coef_valid;
  logic              coef_ready;
  logic [DATA_W-1:0] coef_data;
  logic [ADDR_W-1:0] coef_idx;

  modport master (output coef_valid, coef_data, coef_idx, input coef_ready);
  modport slave  (input coef_valid, coef_data, coef_idx, output coef_ready);

endinterface

// File: rtl/coeff_skid_buf.sv
// Two-entry valid/ready buffer for ROM read returns; an arriving word bypasses
// straight to the output when the buffer is empty.
module coeff_skid_buf #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_idx,
  coeff_loader_if.master    stream,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data_q [2];
  logic [ADDR_W-1:0] idx_q  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              empty;
  logic              push_q;
  logic              pop_q;

  assign empty = (count == 2'd0);

  // Empty with nothing arriving shows zeros so idle/reset outputs are clean.
  assign stream.coef_valid = !empty || in_valid;
  assign stream.coef_data  = !empty ? data_q[rd_ptr] : (in_valid ? in_data : '0);
  assign stream.coef_idx   = !empty ? idx_q[rd_ptr]  : (in_valid ? in_idx  : '0);

  assign pop_q  = !empty && stream.coef_ready;
  assign push_q = in_valid && !(empty && stream.coef_ready);

  always_ff @(posedge clka) begin
    if (rsta) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      if (push_q) begin
        data_q[wr_ptr] <= in_data;
        idx_q[wr_ptr]  <= in_idx;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop_q) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_q) - 2'(pop_q);
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// Fetches NUM_TAPS coefficients from a 1-cycle-latency ROM and streams them out
// in index order. Optional running sum enabled by macro COEFF_LOADER_SUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing ROM addresses 0..NUM_TAPS-1 as buffer space allows
// DRAIN | all addresses issued, waiting for last coefficient to be accepted
module coeff_loader
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     start,
  output logic [ADDR_W-1:0]        addra,
  input  logic [DATA_W-1:0]        douta,
  coeff_loader_if.master           coef,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] coef_sum
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

  load_state_t       state;
  load_state_t       state_nxt;
  logic [ADDR_W-1:0] nxt_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              pend;
  logic [1:0]        buf_cnt;
  logic              start_acc;
  logic              issue;
  logic              xfer;
  logic              last_xfer;

  assign start_acc = start && (state == IDLE) && !done;
  // Occupancy plus in-flight read bounds the lookahead to two words.
  assign issue     = (state == FETCH) && ((buf_cnt + 2'(pend)) < 2'd2);
  assign addra     = issue ? nxt_addr : last_addr;
  assign xfer      = coef.coef_valid && coef.coef_ready;
  assign last_xfer = xfer && (state == DRAIN) && (coef.coef_idx == LAST);
  assign busy      = (state != IDLE) || done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = FETCH;
      FETCH:   if (issue && nxt_addr == LAST) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= IDLE;
      nxt_addr  <= '0;
      last_addr <= '0;
      pend      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= issue;
      done  <= last_xfer;
      if (start_acc) begin
        nxt_addr <= '0;
      end else if (issue) begin
        last_addr <= nxt_addr;
        if (nxt_addr != LAST) nxt_addr <= nxt_addr + ADDR_W'(1);
      end
    end
  end

  // The word in flight always belongs to the most recently issued address.
  coeff_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clka     (clka),
    .rsta     (rsta),
    .in_valid (pend),
    .in_data  (douta),
    .in_idx   (last_addr),
    .stream   (coef),
    .count    (buf_cnt)
  );

`ifdef COEFF_LOADER_SUM_EN
  logic [DATA_W+ADDR_W-1:0] acc;
  logic [DATA_W+ADDR_W-1:0] data_ext;

  assign data_ext = {{ADDR_W{1'b0}}, coef.coef_data};

  always_ff @(posedge clka) begin
    if (rsta) begin
      acc      <= '0;
      coef_sum <= '0;
    end else begin
      if (start_acc)  acc <= '0;
      else if (xfer)  acc <= acc + data_ext;
      if (last_xfer) coef_sum <= acc + data_ext;
    end
  end
`else
  assign coef_sum = '0;
`endif

endmodule

// File: tb/tb_coeff_loader.sv
// Scoreboard bench for coeff_loader: ROM douta = 3*addr+1, randomized ready.
module tb_coeff_loader;

  localparam int NT = 16;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef COEFF_LOADER_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  typedef struct {
    int idx;
    int data;
  } exp_t;

  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] addra;
  logic [DW-1:0] douta = '0;
  logic          busy, done;
  logic [DW+AW-1:0] coef_sum;

  logic          start1 = 1'b0;
  logic [AW-1:0] addra1;
  logic [DW-1:0] douta1 = '0;
  logic          busy1, done1;
  logic [DW+AW-1:0] coef_sum1;

  coeff_loader_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();
  coeff_loader_if #(.ADDR_W(AW), .DATA_W(DW)) cif1 ();

  coeff_loader #(.NUM_TAPS(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clka(clka), .rsta(rsta), .start(start), .addra(addra), .douta(douta),
    .coef(cif), .busy(busy), .done(done), .coef_sum(coef_sum)
  );

  coeff_loader #(.NUM_TAPS(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .clka(clka), .rsta(rsta), .start(start1), .addra(addra1), .douta(douta1),
    .coef(cif1), .busy(busy1), .done(done1), .coef_sum(coef_sum1)
  );

  always #5 clka = ~clka;

  always @(posedge clka) begin
    douta  <= DW'(3 * int'(addra) + 1);
    douta1 <= DW'(3 * int'(addra1) + 1);
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- ready driver ----------------
  int rdy_mode    = 0;
  int stall_until = 0;
  initial begin
    cif.coef_ready  = 1'b1;
    cif1.coef_ready = 1'b1;
    forever begin
      @(posedge clka);
      #1;
      case (rdy_mode)
        1:       cif.coef_ready = ~cif.coef_ready;
        2:       cif.coef_ready = 1'($urandom_range(0, 1));
        3:       cif.coef_ready = (cyc >= stall_until);
        4:       cif.coef_ready = 1'b0;
        default: cif.coef_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  exp_t expq[$];
  int   last_acc  = -1;
  int   done_due  = -1;
  int   model_sum = 0;
  bit   prev_stall = 1'b0;
  int   prev_data, prev_idx;

  always @(negedge clka) begin
    exp_t e;
    if (rsta) begin
      expq.delete();
      last_acc   = -1;
      done_due   = -1;
      model_sum  = 0;
      prev_stall = 1'b0;
    end else begin
      if (!busy) last_acc = -1;
      if (busy) check("addra_window", (int'(addra) <= last_acc + 2), 1);
      if (prev_stall) begin
        check("stall_valid", cif.coef_valid, 1);
        check("stall_data", cif.coef_data, prev_data);
        check("stall_idx", cif.coef_idx, prev_idx);
      end
      if (cif.coef_valid && cif.coef_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          e = expq.pop_front();
          check("xfer_idx", cif.coef_idx, e.idx);
          check("xfer_data", cif.coef_data, e.data);
          if (e.idx == 0) model_sum = 0;
          model_sum += e.data;
          last_acc = e.idx;
          if (e.idx == NT - 1) done_due = cyc + 1;
        end
      end
      if (done || cyc == done_due) begin
        check("done_pulse", done, (cyc == done_due));
        if (done) check("coef_sum", coef_sum, SUM_ON ? model_sum : 0);
      end
      prev_stall = cif.coef_valid && !cif.coef_ready;
      prev_data  = int'(cif.coef_data);
      prev_idx   = int'(cif.coef_idx);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic push_load();
    exp_t e;
    for (int i = 0; i < NT; i++) begin
      e.idx  = i;
      e.data = (3 * i + 1) % (1 << DW);
      expq.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    push_load();
    wait_cyc(cyc + 1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 400) begin
      wait_cyc(cyc + 1);
      n++;
    end
    check(nm, done, 1);
    wait_cyc(cyc + 3);
  endtask

  initial begin
    int nvalid;
    int s;
    int n;

    wait_cyc(3);
    rsta = 1'b0;

    // Nominal load with ready high plus ignored starts at 10 and in the done cycle.
    wait_cyc(5);
    check("idle_busy", busy, 0);
    check("reset_addra", addra, 0);
    check("reset_valid", cif.coef_valid, 0);
    check("reset_sum", coef_sum, 0);
    start = 1'b1;
    push_load();
    nvalid = 0;
    for (int c = 6; c <= 24; c++) begin
      wait_cyc(c);
      start = (c == 10 || c == 23);
      if (cif.coef_valid) nvalid++;
      if (c == 6) begin
        check("t1_busy_c6", busy, 1);
        check("t1_valid_c6", cif.coef_valid, 0);
      end
      if (c == 7) begin
        check("t1_valid_c7", cif.coef_valid, 1);
        check("t1_data_c7", cif.coef_data, 1);
      end
      if (c == 22) begin
        check("t1_idx_c22", cif.coef_idx, 15);
        check("t1_data_c22", cif.coef_data, 46);
      end
      if (c == 23) begin
        check("t1_done_c23", done, 1);
        check("t1_busy_c23", busy, 1);
        check("t1_valid_c23", cif.coef_valid, 0);
      end
      if (c == 24) begin
        check("t1_busy_c24", busy, 0);
        check("t1_done_c24", done, 0);
      end
    end
    start = 1'b0;
    check("t1_valid_count", nvalid, 16);
    wait_cyc(40);
    check("t1_busy_c40", busy, 0);
    check("t1_queue_empty", expq.size(), 0);

    // Toggling ready.
    rdy_mode = 1;
    do_start();
    wait_done("t2_done_timeout");
    check("t2_queue_empty", expq.size(), 0);

    // Ready held low for 20 cycles after start.
    rdy_mode = 3;
    s = cyc;
    stall_until = s + 21;
    do_start();
    wait_cyc(s + 12);
    check("t3_addra_stop", addra, 1);
    check("t3_valid_held", cif.coef_valid, 1);
    check("t3_idx_held", cif.coef_idx, 0);
    check("t3_data_held", cif.coef_data, 1);
    wait_done("t3_done_timeout");
    check("t3_queue_empty", expq.size(), 0);

    // Random ready, reset after idx 5 accepted, then a fresh load.
    rdy_mode = 2;
    do_start();
    n = 0;
    while (last_acc != 5 && n < 400) begin
      @(posedge clka);
      n++;
    end
    check("t4_idx5_timeout", last_acc, 5);
    #2;
    rdy_mode = 4;
    cif.coef_ready = 1'b0;
    rsta = 1'b1;
    @(posedge clka);
    #2;
    rsta = 1'b0;
    check("t4_rst_addra", addra, 0);
    check("t4_rst_valid", cif.coef_valid, 0);
    check("t4_rst_data", cif.coef_data, 0);
    check("t4_rst_idx", cif.coef_idx, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_sum", coef_sum, 0);
    wait_cyc(cyc + 10);
    check("t4_idle_after_rst", busy, 0);
    rdy_mode = 2;
    do_start();
    wait_done("t4_done_timeout");
    check("t4_queue_empty", expq.size(), 0);

    // Single-tap instance.
    s = cyc;
    start1 = 1'b1;
    check("t5_idle_busy", busy1, 0);
    wait_cyc(s + 1);
    start1 = 1'b0;
    check("t5_busy", busy1, 1);
    check("t5_addra", addra1, 0);
    check("t5_valid_early", cif1.coef_valid, 0);
    wait_cyc(s + 2);
    check("t5_valid", cif1.coef_valid, 1);
    check("t5_data", cif1.coef_data, 1);
    check("t5_idx", cif1.coef_idx, 0);
    check("t5_done_early", done1, 0);
    wait_cyc(s + 3);
    check("t5_done", done1, 1);
    check("t5_valid_after", cif1.coef_valid, 0);
    check("t5_sum", coef_sum1, SUM_ON ? 1 : 0);
    wait_cyc(s + 4);
    check("t5_busy_after", busy1, 0);
    check("t5_done_after", done1, 0);

    wait_cyc(cyc + 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 Parameter NUM_TAPS, default 16, number of coefficients fetched per load (1..2**ADDR_W).
REQ-002 Parameter ADDR_W, default 4, coefficient ROM address width.
REQ-003 Parameter DATA_W, default 8, coefficient width.
REQ-004 clka  in  1  sole clock, all logic on rising edge.
REQ-005 rsta  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle load request.
REQ-007 addra  out  ADDR_W  address to filter_coeff ROM.
REQ-008 douta  in  DATA_W  ROM read data, valid exactly 1 cycle after addra.
REQ-009 coef_valid  out  1  coef_data/coef_idx valid.
REQ-010 coef_ready  in  1  downstream accepts when high with coef_valid.
REQ-011 coef_data  out  DATA_W  coefficient.
REQ-012 coef_idx  out  ADDR_W  tap index of coef_data.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  one-cycle pulse, last coefficient accepted.
REQ-015 coef_sum  out  DATA_W+ADDR_W  unsigned sum of coefficients of last completed load.

Function
REQ-016 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after address NUM_TAPS-1 issued; DRAIN->IDLE on acceptance of idx NUM_TAPS-1.
REQ-017 Addresses issued in order 0..NUM_TAPS-1, one per cycle max; addra holds last value when not issuing.
REQ-018 Read returns captured into 2-entry output buffer; new address issued only if (buffer occupancy + reads in flight) < 2.
REQ-019 Coefficients delivered in index order, none dropped or duplicated, under any coef_ready pattern.
REQ-020 Transfer occurs when coef_valid && coef_ready; coef_data/coef_idx stable while coef_valid && !coef_ready.
REQ-021 With coef_ready held high: first coef_valid 2 cycles after start, one coefficient per cycle thereafter, done 1 cycle after last transfer.
REQ-022 busy high from cycle after start until cycle done asserts; low in IDLE.
REQ-023 start while busy ignored; start in same cycle as done pulse ignored (busy still high).
REQ-024 NUM_TAPS=1: FETCH lasts one cycle, single transfer, done follows.
REQ-025 Addresses never exceed NUM_TAPS-1; no wrap within one load; next load restarts at 0.

Reset
REQ-026 rsta high: FSM->IDLE, buffer emptied, in-flight read discarded, addra=0, coef_valid=0, coef_data=0, coef_idx=0, busy=0, done=0, coef_sum=0.
REQ-027 rsta mid-load aborts load with no done pulse; start ignored in any cycle rsta high.

Configuration
REQ-028 Macro COEFF_LOADER_SUM_EN defined: accumulator cleared on start accepted, adds each transferred coef_data, copied to coef_sum in done cycle, held until next done or reset.
REQ-029 Macro undefined: coef_sum tied to 0, no accumulator logic; all other behaviour identical.

Structure
REQ-030 Shared package fir_pkg holds FSM state encoding and default ADDR_W/DATA_W/NUM_TAPS constants.
REQ-031 Sub-module coeff_skid_buf (2-entry valid/ready buffer, data+idx) instantiated once; no other sub-modules.

Verification
REQ-032 Bench ROM model douta = 3*addr+1, 1-cycle latency, NUM_TAPS=16, coef_ready=1, start at cycle 5 -> coef_valid cycles 7..22, coef_data 1,4,..,46, done cycle 23, coef_sum=376 (macro on).
REQ-033 coef_ready toggling 1,0,1,0 -> 16 transfers in idx order 0..15, data stable during stalls, addra never more than 2 ahead of last accepted idx.
REQ-034 coef_ready=0 for 20 cycles after start -> exactly 2 buffered, addra stops at 1, transfers resume in order when ready rises.
REQ-035 rsta asserted after idx 5 accepted -> next cycle all outputs at reset values, no done; new start fetches from addr 0.
REQ-036 start pulses at cycle 10 while busy and in done cycle -> ignored, single load of 16; NUM_TAPS=1 build -> one transfer (data 1), done.
REQ-037 Macro undefined build, REQ-032 stimulus -> identical stream and timing, coef_sum=0.
